cdwu: RTL



---
 rtl/cdwu_pkg.sv | 23 ++
 rtl/cdwu_slot.sv | 37 +++
 rtl/cdwu.sv | 102 ++++++++++
 3 files changed

// File: rtl/cdwu_pkg.sv
// cdwu_pkg: shared write-source codes and the scratchpad bank-extraction convention.
// Used by cdwu, the read unit and the read-data return path.
//   MUX_I/MUX_D/MUX_C : muxcode values naming the write source
//   bank_eq()         : compares the addr[wb +: bb] bank fields of two addresses
package cdwu_pkg;

    localparam logic [1:0] MUX_I = 2'd0;
    localparam logic [1:0] MUX_D = 2'd1;
    localparam logic [1:0] MUX_C = 2'd2;

    // Addresses are passed zero-extended to 64 bits so one helper serves every address width.
    function automatic logic bank_eq(
        input logic [63:0] a,
        input logic [63:0] b,
        input int unsigned wb,
        input int unsigned bb
    );
        logic [63:0] mask;
        mask = (64'd1 << bb) - 64'd1;
        return (((a ^ b) >> wb) & mask) == 64'd0;
    endfunction

endpackage

// File: rtl/cdwu_slot.sv
// cdwu_slot: one-entry write holding register with load, clear and same-edge refill.
// Ports:
//   clk, rst_n       : clock, synchronous active-low reset
//   load             : capture in_addr/in_data and set pend (wins over clear)
//   clear            : drop pend (held write has issued)
//   in_addr, in_data : incoming write
//   pend, addr, data : slot contents
module cdwu_slot #(
    parameter int A        = 14,
    parameter int DATABITS = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load,
    input  logic                clear,
    input  logic [A-1:0]        in_addr,
    input  logic [DATABITS-1:0] in_data,
    output logic                pend,
    output logic [A-1:0]        addr,
    output logic [DATABITS-1:0] data
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend <= 1'b0;
            addr <= '0;
            data <= '0;
        end else if (load) begin
            pend <= 1'b1;
            addr <= in_addr;
            data <= in_data;
        end else if (clear) begin
            pend <= 1'b0;
        end
    end

endmodule

// File: rtl/cdwu.sv
// cdwu: arbitrates three write sources (i, d, c) onto the scratchpad write port, avoiding the read's bank.
// Ports:
//   clk, rst_n                 : clock, synchronous active-low reset
//   {i,d,c}_en/_addr/_data     : write requests, held by the source until _rdy
//   {i,d,c}_rdy                : holding slot can accept this cycle
//   rd_en, rd_addr             : read issued this cycle; its bank blocks writes
//   o_en, o_addr, o_data       : write issued this cycle
//   muxcode                    : issuing source (MUX_I/MUX_D/MUX_C)
// Build option: CDWU_ROUNDROBIN_EN selects round-robin arbitration instead of fixed i > d > c.
module cdwu
    import cdwu_pkg::*;
#(
    parameter int BANKBITS = 5,
    parameter int WORDBITS = 9,
    parameter int DATABITS = 64,
    localparam int A = BANKBITS + WORDBITS
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_en,
    input  logic [A-1:0]        i_addr,
    input  logic [DATABITS-1:0] i_data,
    output logic                i_rdy,
    input  logic                d_en,
    input  logic [A-1:0]        d_addr,
    input  logic [DATABITS-1:0] d_data,
    output logic                d_rdy,
    input  logic                c_en,
    input  logic [A-1:0]        c_addr,
    input  logic [DATABITS-1:0] c_data,
    output logic                c_rdy,
    input  logic                rd_en,
    input  logic [A-1:0]        rd_addr,
    output logic                o_en,
    output logic [A-1:0]        o_addr,
    output logic [DATABITS-1:0] o_data,
    output logic [1:0]          muxcode
);

    logic [2:0]          en, pend, elig, granted, rdy;
    logic [A-1:0]        in_addr [3];
    logic [A-1:0]        s_addr  [3];
    logic [DATABITS-1:0] in_data [3];
    logic [DATABITS-1:0] s_data  [3];
    logic [1:0]          win;

    assign en = {c_en, d_en, i_en};
    assign in_addr[0] = i_addr;
    assign in_addr[1] = d_addr;
    assign in_addr[2] = c_addr;
    assign in_data[0] = i_data;
    assign in_data[1] = d_data;
    assign in_data[2] = c_data;
    assign {c_rdy, d_rdy, i_rdy} = rdy;

    for (genvar g = 0; g < 3; g++) begin : g_slot
        assign elig[g]    = pend[g] & ~(rd_en & bank_eq(64'(s_addr[g]), 64'(rd_addr), WORDBITS, BANKBITS));
        assign granted[g] = o_en & (win == 2'(g));
        // Refill on the issuing edge keeps a lone source at one write per cycle.
        assign rdy[g]     = ~pend[g] | granted[g];
        cdwu_slot #(.A(A), .DATABITS(DATABITS)) u_slot (
            .clk     (clk),
            .rst_n   (rst_n),
            .load    (en[g] & rdy[g]),
            .clear   (granted[g]),
            .in_addr (in_addr[g]),
            .in_data (in_data[g]),
            .pend    (pend[g]),
            .addr    (s_addr[g]),
            .data    (s_data[g])
        );
    end

`ifdef CDWU_ROUNDROBIN_EN
    logic [1:0] last;

    // Walk candidates farthest-first so the source nearest after last overwrites the others.
    always_comb begin
        int idx;
        idx = 0;
        win = MUX_I;
        for (int k = 3; k >= 1; k--) begin
            idx = (int'(last) + k) % 3;
            if (elig[idx]) win = 2'(idx);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) last <= MUX_C;
        else if (o_en) last <= win;
    end
`else
    always_comb win = elig[0] ? MUX_I : elig[1] ? MUX_D : elig[2] ? MUX_C : MUX_I;
`endif

    // With nothing eligible win stays MUX_I, so the outputs show slot i as required.
    assign o_en    = |elig;
    assign muxcode = win;
    assign o_addr  = win == MUX_D ? s_addr[1] : win == MUX_C ? s_addr[2] : s_addr[0];
    assign o_data  = win == MUX_D ? s_data[1] : win == MUX_C ? s_data[2] : s_data[0];

endmodule
